ir_nec_decoder: RTL

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_nec_pkg.sv | 35 +++
 rtl/ir_pulse_timer.sv | 60 ++++++
 rtl/ir_nec_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC decoder definitions: FSM states, pulse-width windows in ticks,
// frame length and a window-check helper.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    REP_STOP
  } state_e;

  localparam logic [8:0] T_LEAD_LOW_MIN  = 9'd300;
  localparam logic [8:0] T_LEAD_LOW_MAX  = 9'd400;
  localparam logic [8:0] T_LEAD_HIGH_MIN = 9'd150;
  localparam logic [8:0] T_LEAD_HIGH_MAX = 9'd200;
  localparam logic [8:0] T_REP_HIGH_MIN  = 9'd70;
  localparam logic [8:0] T_REP_HIGH_MAX  = 9'd110;
  localparam logic [8:0] T_SHORT_MIN     = 9'd12;
  localparam logic [8:0] T_SHORT_MAX     = 9'd32;
  localparam logic [8:0] T_LONG_MIN      = 9'd50;
  localparam logic [8:0] T_LONG_MAX      = 9'd80;
  localparam logic [8:0] T_DUR_MAX       = 9'd511;

  localparam int unsigned FRAME_BITS = 32;

  function automatic logic in_range(input logic [8:0] v,
                                    input logic [8:0] lo,
                                    input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// IR input conditioning: 2-FF synchronizer, edge detect, free-running tick
// prescaler and a saturating 9-bit pulse-duration counter cleared on edges.
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_in,
  output logic       rise,
  output logic       fall,
  output logic [8:0] dur
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [8:0]    dur_q, dur_d;
  logic          tick;

  always_comb begin
    sync1_d = ir_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    if (sync2_q != prev_q)
      dur_d = '0;
    else if (tick && (dur_q != T_DUR_MAX))
      dur_d = dur_q + 1'b1;
    else
      dur_d = dur_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;
  assign dur  = dur_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: measures pulse widths via ir_pulse_timer and walks
// leader / 32 data bits / stop, or leader / repeat stop, with a timeout.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        valid,
  output logic        repeat_p,
  output logic        err,
  output logic        busy
);

  logic       rise, fall;
  logic [8:0] dur;

  ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .ir_in (ir_in),
    .rise  (rise),
    .fall  (fall),
    .dur   (dur)
  );

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        have_cmd_q, have_cmd_d;
  logic        valid_q, valid_d;
  logic        repeat_q, repeat_d;
  logic        err_q, err_d;
  logic        is_short, is_long;

  assign is_short = in_range(dur, T_SHORT_MIN, T_SHORT_MAX);
  assign is_long  = in_range(dur, T_LONG_MIN, T_LONG_MAX);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    have_cmd_d = have_cmd_q;
    valid_d    = 1'b0;
    repeat_d   = 1'b0;
    err_d      = 1'b0;
    // Timeout is checked first so it overrides an edge seen in the same clk.
    if ((state_q != IDLE) && (dur == T_DUR_MAX)) begin
      state_d = IDLE;
      err_d   = (state_q != LEAD_LOW);
    end else begin
      case (state_q)
        IDLE: if (fall) state_d = LEAD_LOW;
        LEAD_LOW: if (rise)
          state_d = in_range(dur, T_LEAD_LOW_MIN, T_LEAD_LOW_MAX) ? LEAD_HIGH : IDLE;
        LEAD_HIGH: if (fall) begin
          if (in_range(dur, T_LEAD_HIGH_MIN, T_LEAD_HIGH_MAX)) begin
            state_d   = BIT_LOW;
            bit_cnt_d = '0;
          end else if (in_range(dur, T_REP_HIGH_MIN, T_REP_HIGH_MAX)) begin
            state_d = REP_STOP;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        BIT_LOW: if (rise) begin
          state_d = is_short ? BIT_HIGH : IDLE;
          err_d   = !is_short;
        end
        BIT_HIGH: if (fall) begin
          if (is_short || is_long) begin
            shift_d   = {is_long, shift_q[31:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = (bit_cnt_q == 6'(FRAME_BITS - 1)) ? STOP_LOW : BIT_LOW;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        STOP_LOW: if (rise) begin
          state_d = IDLE;
          if (is_short && ((shift_q[23:16] ^ shift_q[31:24]) == 8'hFF)) begin
            addr_d     = shift_q[15:0];
            cmd_d      = shift_q[23:16];
            valid_d    = 1'b1;
            have_cmd_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        REP_STOP: if (rise) begin
          state_d  = IDLE;
          repeat_d = is_short && have_cmd_q;
          err_d    = !is_short;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      have_cmd_q <= 1'b0;
      valid_q    <= 1'b0;
      repeat_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      have_cmd_q <= have_cmd_d;
      valid_q    <= valid_d;
      repeat_q   <= repeat_d;
      err_q      <= err_d;
    end
  end

  assign addr     = addr_q;
  assign cmd      = cmd_q;
  assign valid    = valid_q;
  assign repeat_p = repeat_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule
